// File: rtl/vga_sync_generator.sv
// Vertical line counter and registered VGA sync/video/coordinate decode,
// driven by the horizontal pixel count and its line-wrap strobe.
module vga_sync_generator #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOTAL   = 525,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        enable_V_counter,
    input  logic [15:0] H_count_Value,
    output logic [15:0] V_count_Value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic        timing_err
);

    localparam int unsigned CW = 16;
    localparam int unsigned PW = 10;

    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] H_SYNC_S = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] H_TOT    = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] V_SYNC_S = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [CW-1:0] r_v_count;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;
    logic [PW-1:0] r_pixel_x;
    logic [PW-1:0] r_pixel_y;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_timing_err;

    logic [CW-1:0] w_next_v;
    logic [CW-1:0] w_line;
    logic          w_video_on;
    logic          w_hsync_act;
    logic          w_vsync_act;
    logic          w_seq_err;

    // A strobe sample decodes against the line it opens, not the one it closes.
    always_comb begin
        w_next_v    = '0;
        w_line      = r_v_count;
        w_video_on  = 1'b0;
        w_hsync_act = 1'b0;
        w_vsync_act = 1'b0;
        w_seq_err   = 1'b0;

        if (r_v_count != V_LAST) begin
            w_next_v = r_v_count + CW'(1);
        end
        if (enable_V_counter) begin
            w_line = w_next_v;
        end

        w_video_on  = (H_count_Value < H_VIS) && (w_line < V_VIS);
        w_hsync_act = (H_count_Value >= H_SYNC_S) && (H_count_Value < H_SYNC_E);
        w_vsync_act = (w_line >= V_SYNC_S) && (w_line < V_SYNC_E);
        w_seq_err   = (H_count_Value >= H_TOT) ||
                      (enable_V_counter && (H_count_Value != '0));
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_v_count     <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            if (enable_V_counter) begin
                r_v_count <= w_next_v;
            end
            r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video_on;
            r_pixel_x     <= w_video_on ? H_count_Value[PW-1:0] : '0;
            r_pixel_y     <= w_video_on ? w_line[PW-1:0] : '0;
            r_line_start  <= enable_V_counter;
            r_frame_start <= enable_V_counter && (w_next_v == '0);
            // Sticky until reset so a single glitch upstream is never missed.
            r_timing_err  <= r_timing_err | w_seq_err;
        end
    end

    assign V_count_Value = r_v_count;
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign video_on      = r_video_on;
    assign pixel_x       = r_pixel_x;
    assign pixel_y       = r_pixel_y;
    assign line_start    = r_line_start;
    assign frame_start   = r_frame_start;
    assign timing_err    = r_timing_err;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench for vga_sync_generator: vector table plus multi-cycle
// sequences for vertical wrap, frame pulses, errors and mid-frame reset.
module tb_vga_sync_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] h;
    logic [15:0] v_out;
    logic        hs, vs, vid, ls, fs, err;
    logic [9:0]  px, py;

    int n_pass  = 0;
    int n_total = 0;

    always #20 clk = ~clk;

    vga_sync_generator dut (
        .clk_25MHz        (clk),
        .rst_n            (rst_n),
        .enable_V_counter (en),
        .H_count_Value    (h),
        .V_count_Value    (v_out),
        .hsync            (hs),
        .vsync            (vs),
        .video_on         (vid),
        .pixel_x          (px),
        .pixel_y          (py),
        .line_start       (ls),
        .frame_start      (fs),
        .timing_err       (err)
    );

    typedef struct {
        logic        en;
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vid;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        ls;
        logic        fs;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all(input string tag, input vec_t x);
        chk({tag, ".V"},     32'(v_out), 32'(x.v));
        chk({tag, ".hsync"}, 32'(hs),    32'(x.hs));
        chk({tag, ".vsync"}, 32'(vs),    32'(x.vs));
        chk({tag, ".video"}, 32'(vid),   32'(x.vid));
        chk({tag, ".px"},    32'(px),    32'(x.px));
        chk({tag, ".py"},    32'(py),    32'(x.py));
        chk({tag, ".ls"},    32'(ls),    32'(x.ls));
        chk({tag, ".fs"},    32'(fs),    32'(x.fs));
        chk({tag, ".err"},   32'(err),   32'(x.err));
    endtask

    // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
    task automatic step(input logic e, input logic [15:0] hv);
        @(negedge clk);
        en = e;
        h  = hv;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        step(1'b1, 16'd0);
        step(1'b0, 16'd1);
    endtask

    function automatic vec_t rst_vec();
        vec_t r;
        r = '{en: 1'b0, h: 16'd0, v: 16'd0, hs: 1'b1, vs: 1'b1, vid: 1'b0,
              px: 10'd0, py: 10'd0, ls: 1'b0, fs: 1'b0, err: 1'b0};
        return r;
    endfunction

    initial begin
        int ls_cnt, fs_cnt, fs_first, fs_second, vid_cnt, hs_cnt, k;
        vec_t e;
        logic [15:0] line;

        rst_n = 1'b0;
        en    = 1'b0;
        h     = 16'd0;
        #50;
        chk_all("reset", rst_vec());
        @(negedge clk);
        rst_n = 1'b1;

        // Advance to line 9, then the table opens line 10.
        for (int i = 0; i < 9; i++) strobe();

        //         en    h        V       hs    vs    vid   px       py      ls    fs    err
        vecs[0] = '{1'b1, 16'd0,   16'd10, 1'b1, 1'b1, 1'b1, 10'd0,   10'd10, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'd639, 16'd10, 1'b1, 1'b1, 1'b1, 10'd639, 10'd10, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'd640, 16'd10, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'd655, 16'd10, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'd656, 16'd10, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'd751, 16'd10, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'd752, 16'd10, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,  1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 16'd799, 16'd10, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,  1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 16'd0,   16'd11, 1'b1, 1'b1, 1'b1, 10'd0,   10'd11, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 16'd100, 16'd11, 1'b1, 1'b1, 1'b1, 10'd100, 10'd11, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].h);
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Vertical region walk across the visible/blank edge and the vsync pulse.
        for (int i = 0; i < 466; i++) strobe();
        for (int l = 478; l <= 493; l++) begin
            line = 16'(l);
            step(1'b1, 16'd0);
            chk($sformatf("l%0d.V", l), 32'(v_out), 32'(line));
            chk($sformatf("l%0d.vid", l), 32'(vid), (l < 480) ? 32'd1 : 32'd0);
            chk($sformatf("l%0d.py", l), 32'(py), (l < 480) ? 32'(l) : 32'd0);
            chk($sformatf("l%0d.px", l), 32'(px), 32'd0);
            chk($sformatf("l%0d.vs", l), 32'(vs), (l == 490 || l == 491) ? 32'd0 : 32'd1);
            step(1'b0, 16'd300);
            chk($sformatf("l%0d.vs_mid", l), 32'(vs), (l == 490 || l == 491) ? 32'd0 : 32'd1);
            chk($sformatf("l%0d.py_mid", l), 32'(py), (l < 480) ? 32'(l) : 32'd0);
        end

        // Run up to the last line, then the wrap strobe.
        for (int i = 494; i <= 524; i++) strobe();
        chk("pre_wrap.V", 32'(v_out), 32'd524);
        step(1'b1, 16'd0);
        chk("wrap.V",  32'(v_out), 32'd0);
        chk("wrap.ls", 32'(ls), 32'd1);
        chk("wrap.fs", 32'(fs), 32'd1);
        step(1'b0, 16'd1);
        chk("wrap.fs_drop", 32'(fs), 32'd0);

        // Two full free-running lines on lines 1 and 2.
        for (int ln = 1; ln <= 2; ln++) begin
            vid_cnt = 0;
            hs_cnt  = 0;
            for (int x = 0; x < 800; x++) begin
                step(x == 0, 16'(x));
                if (vid) vid_cnt++;
                if (!hs) hs_cnt++;
            end
            chk($sformatf("line%0d.video_cnt", ln), 32'(vid_cnt), 32'd640);
            chk($sformatf("line%0d.hsync_cnt", ln), 32'(hs_cnt), 32'd96);
            chk($sformatf("line%0d.V", ln), 32'(v_out), 32'(ln));
        end

        // Two frames of strobes starting from line 2.
        ls_cnt = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
        for (int i = 0; i < 1050; i++) begin
            step(1'b1, 16'd0);
            if (ls) ls_cnt++;
            if (fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i; else fs_second = i;
            end
            step(1'b0, 16'd1);
            if (ls) ls_cnt++;
            if (fs) fs_cnt++;
        end
        chk("frames.ls_cnt", 32'(ls_cnt), 32'd1050);
        chk("frames.fs_cnt", 32'(fs_cnt), 32'd2);
        chk("frames.fs_first", 32'(fs_first), 32'd522);
        chk("frames.fs_period", 32'(fs_second - fs_first), 32'd525);
        chk("frames.V", 32'(v_out), 32'd2);
        chk("frames.err", 32'(err), 32'd0);

        // Mid-frame asynchronous reset at line 300, pixel 400.
        for (int i = 0; i < 298; i++) strobe();
        step(1'b0, 16'd400);
        chk("mid.V",   32'(v_out), 32'd300);
        chk("mid.vid", 32'(vid), 32'd1);
        chk("mid.px",  32'(px), 32'd400);
        chk("mid.py",  32'(py), 32'd300);
        #5;
        rst_n = 1'b0;
        #1;
        e = rst_vec();
        chk_all("async_rst", e);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 16'd5);
        step(1'b0, 16'd6);
        chk("post_rst.ls", 32'(ls), 32'd0);
        chk("post_rst.fs", 32'(fs), 32'd0);
        chk("post_rst.V",  32'(v_out), 32'd0);
        k = 0;
        fs_first = -1;
        while (fs_first < 0 && k < 600) begin
            k++;
            step(1'b1, 16'd0);
            if (fs) fs_first = k;
            step(1'b0, 16'd1);
        end
        chk("post_rst.first_fs", 32'(fs_first), 32'd525);
        chk("post_rst.V_wrap", 32'(v_out), 32'd0);

        // Out-of-range H: blanked, error raised and held.
        step(1'b0, 16'd800);
        chk("h800.err", 32'(err), 32'd1);
        chk("h800.vid", 32'(vid), 32'd0);
        chk("h800.hs",  32'(hs), 32'd1);
        chk("h800.V",   32'(v_out), 32'd0);
        step(1'b0, 16'd10);
        step(1'b0, 16'd11);
        chk("h800.err_sticky", 32'(err), 32'd1);
        chk("h800.px_after", 32'(px), 32'd11);

        // Stray strobe at H=5 from a clean reset.
        @(negedge clk);
        rst_n = 1'b0;
        #5;
        chk("rst2.err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 16'd5);
        chk("pre_stray.err", 32'(err), 32'd0);
        step(1'b1, 16'd5);
        chk("stray.V",   32'(v_out), 32'd1);
        chk("stray.err", 32'(err), 32'd1);
        chk("stray.ls",  32'(ls), 32'd1);
        chk("stray.px",  32'(px), 32'd5);
        chk("stray.py",  32'(py), 32'd1);
        step(1'b0, 16'd6);
        step(1'b0, 16'd7);
        chk("stray.V_hold",     32'(v_out), 32'd1);
        chk("stray.err_sticky", 32'(err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
